cache_mem_arbiter: RTL and testbench

//  Shares one line-wide memory port between two direct-mapped cache controllers (s0 = I-cache, s1 = D-cache).

---
 rtl/cache_mem_arbiter_if.sv | 58 +++++
 rtl/cache_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of every signal between the cache/memory arbiter and its neighbours:
// the two cache controller request/response ports, the shared memory port,
// the sticky overrun flags and the FSM state for observation.
//
// Handshake rules:
// - sN_req_valid_i is a single-cycle request pulse.
// - sN_mem_ready_o is a single-cycle completion pulse, and sN_mem_data_o is
//   valid with it.
// - mem_req_valid_o stays high, with rw/addr/data stable, until the memory
//   returns a one-cycle mem_ready_i. mem_data_i is valid with mem_ready_i.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              s0_req_valid_i;
  logic              s0_req_rw_i;
  logic [ADDR_W-1:0] s0_req_addr_i;
  logic [LINE_W-1:0] s0_req_data_i;
  logic              s0_mem_ready_o;
  logic [LINE_W-1:0] s0_mem_data_o;

  logic              s1_req_valid_i;
  logic              s1_req_rw_i;
  logic [ADDR_W-1:0] s1_req_addr_i;
  logic [LINE_W-1:0] s1_req_data_i;
  logic              s1_mem_ready_o;
  logic [LINE_W-1:0] s1_mem_data_o;

  logic              mem_req_valid_o;
  logic              mem_req_rw_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [LINE_W-1:0] mem_req_data_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_data_i;

  logic [1:0]        err_o;
  logic [1:0]        dbg_state_o;

  // Arbiter side.
  modport master (
    input  s0_req_valid_i, s0_req_rw_i, s0_req_addr_i, s0_req_data_i,
    input  s1_req_valid_i, s1_req_rw_i, s1_req_addr_i, s1_req_data_i,
    input  mem_ready_i, mem_data_i,
    output s0_mem_ready_o, s0_mem_data_o, s1_mem_ready_o, s1_mem_data_o,
    output mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o,
    output err_o, dbg_state_o
  );

  // Environment side: cache controllers plus memory.
  modport slave (
    output s0_req_valid_i, s0_req_rw_i, s0_req_addr_i, s0_req_data_i,
    output s1_req_valid_i, s1_req_rw_i, s1_req_addr_i, s1_req_data_i,
    output mem_ready_i, mem_data_i,
    input  s0_mem_ready_o, s0_mem_data_o, s1_mem_ready_o, s1_mem_data_o,
    input  mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o,
    input  err_o, dbg_state_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between the I-cache (port 0) and the
// D-cache (port 1). Each request pulse is parked in a per-port pending slot.
// Pending slots are granted round-robin, and one memory transaction runs at a
// time. The completion pulse and read data go back to the granted port only.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q;
  logic [1:0]        pending_q;
  logic [1:0]        err_q;
  logic [1:0]        req_v, capture, overrun, clr;
  logic              busy, done;

  logic              rw0_q, rw1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [LINE_W-1:0] data0_q, data1_q;

  logic              rdy0_q, rdy1_q;
  logic [LINE_W-1:0] rdata0_q, rdata1_q;

  assign req_v   = {bus.s1_req_valid_i, bus.s0_req_valid_i};
  // A pulse that finds its slot still occupied is an overrun and is dropped.
  assign capture = req_v & ~pending_q;
  assign overrun = req_v & pending_q;
  assign done    = (state_q == WAIT) && bus.mem_ready_i;
  assign clr     = done ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

  // Pending slots and sticky overrun flags; capture runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 2'b00;
      err_q     <= 2'b00;
      rw0_q     <= 1'b0;
      addr0_q   <= '0;
      data0_q   <= '0;
      rw1_q     <= 1'b0;
      addr1_q   <= '0;
      data1_q   <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | capture;
      err_q     <= err_q | overrun;
      if (capture[0]) begin
        rw0_q   <= bus.s0_req_rw_i;
        addr0_q <= bus.s0_req_addr_i;
        data0_q <= bus.s0_req_data_i;
      end
      if (capture[1]) begin
        rw1_q   <= bus.s1_req_rw_i;
        addr1_q <= bus.s1_req_addr_i;
        data1_q <= bus.s1_req_data_i;
      end
    end
  end

  // FSM state, current grant and round-robin history.
  // last_grant starts at 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (done) begin
        last_grant_q <= grant_q;
      end
    end
  end

  // Next-state and grant selection. The memory request is up in ISSUE and WAIT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d = (&pending_q) ? ~last_grant_q : pending_q[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (bus.mem_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulse and read-data hold. The data is returned for writes too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdy0_q <= done && !grant_q;
      rdy1_q <= done && grant_q;
      if (done && !grant_q) begin
        rdata0_q <= bus.mem_data_i;
      end
      if (done && grant_q) begin
        rdata1_q <= bus.mem_data_i;
      end
    end
  end

  // Memory request fields come from the granted slot and are zero while idle.
  assign bus.mem_req_valid_o = busy;
  assign bus.mem_req_rw_o    = busy && (grant_q ? rw1_q : rw0_q);
  assign bus.mem_req_addr_o  = busy ? (grant_q ? addr1_q : addr0_q) : '0;
  assign bus.mem_req_data_o  = busy ? (grant_q ? data1_q : data0_q) : '0;

  assign bus.s0_mem_ready_o  = rdy0_q;
  assign bus.s0_mem_data_o   = rdata0_q;
  assign bus.s1_mem_ready_o  = rdy1_q;
  assign bus.s1_mem_data_o   = rdata1_q;
  assign bus.err_o           = err_q;
  assign bus.dbg_state_o     = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter.
// A per-cycle vector table covers the single-read latency and the
// round-robin alternation. Hand-written sequences cover write-back/allocate
// ordering, overrun, a stray memory ready and a reset during WAIT.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  localparam logic [LINE_W-1:0] D_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [LINE_W-1:0] DA = 128'hAAAA_0001_AAAA_0001_AAAA_0001_AAAA_0001;
  localparam logic [LINE_W-1:0] DB = 128'hBBBB_0002_BBBB_0002_BBBB_0002_BBBB_0002;
  localparam logic [LINE_W-1:0] DC = 128'hCCCC_0003_CCCC_0003_CCCC_0003_CCCC_0003;
  localparam logic [LINE_W-1:0] DD = 128'hDDDD_0004_DDDD_0004_DDDD_0004_DDDD_0004;
  localparam logic [LINE_W-1:0] DE = 128'hEEEE_0005_EEEE_0005_EEEE_0005_EEEE_0005;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [ADDR_W-1:0] exp_q[$];

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              s0v;
    logic              s1v;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic              mrdy;
    logic [LINE_W-1:0] mdata;
    logic              ev;
    logic [ADDR_W-1:0] eaddr;
    logic              er0;
    logic              er1;
    logic [LINE_W-1:0] ed0;
    logic [LINE_W-1:0] ed1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic s0v, logic s1v, logic [ADDR_W-1:0] a0,
                              logic [ADDR_W-1:0] a1, logic mrdy, logic [LINE_W-1:0] mdata,
                              logic ev, logic [ADDR_W-1:0] eaddr, logic er0, logic er1,
                              logic [LINE_W-1:0] ed0, logic [LINE_W-1:0] ed1);
    vec_t v;
    v.rst = rst; v.s0v = s0v; v.s1v = s1v; v.a0 = a0; v.a1 = a1;
    v.mrdy = mrdy; v.mdata = mdata; v.ev = ev; v.eaddr = eaddr;
    v.er0 = er0; v.er1 = er1; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  // Write data is derived from the address so the data bus can be checked.
  function automatic logic [LINE_W-1:0] wd(logic [ADDR_W-1:0] a);
    return {a, ~a, a, ~a};
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s0_req_valid_i = 1'b0; bus.s0_req_rw_i = 1'b0;
    bus.s0_req_addr_i = '0;    bus.s0_req_data_i = '0;
    bus.s1_req_valid_i = 1'b0; bus.s1_req_rw_i = 1'b0;
    bus.s1_req_addr_i = '0;    bus.s1_req_data_i = '0;
    bus.mem_ready_i = 1'b0;    bus.mem_data_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mv"},    128'(bus.mem_req_valid_o), '0);
    chk({tag, "_mrw"},   128'(bus.mem_req_rw_o), '0);
    chk({tag, "_maddr"}, 128'(bus.mem_req_addr_o), '0);
    chk({tag, "_mdata"}, bus.mem_req_data_o, '0);
    chk({tag, "_r0"},    128'(bus.s0_mem_ready_o), '0);
    chk({tag, "_r1"},    128'(bus.s1_mem_ready_o), '0);
    chk({tag, "_d0"},    bus.s0_mem_data_o, '0);
    chk({tag, "_d1"},    bus.s1_mem_data_o, '0);
    chk({tag, "_err"},   128'(bus.err_o), '0);
    chk({tag, "_state"}, 128'(bus.dbg_state_o), '0);
  endtask

  // Driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int port, input logic rw, input logic [ADDR_W-1:0] a);
    if (port == 0) begin
      bus.s0_req_valid_i = 1'b1; bus.s0_req_rw_i = rw;
      bus.s0_req_addr_i = a;     bus.s0_req_data_i = wd(a);
    end else begin
      bus.s1_req_valid_i = 1'b1; bus.s1_req_rw_i = rw;
      bus.s1_req_addr_i = a;     bus.s1_req_data_i = wd(a);
    end
    tick();
    bus.s0_req_valid_i = 1'b0;
    bus.s1_req_valid_i = 1'b0;
  endtask

  // Memory model: wait for a request and check it against the scoreboard.
  // Keep it stable for 'hold' cycles, then return rd with a ready pulse.
  task automatic serve(input logic [LINE_W-1:0] rd, input logic exp_rw, input int hold);
    int n;
    logic [ADDR_W-1:0] ea;
    n = 0;
    while (bus.mem_req_valid_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL serve_timeout: no mem_req_valid_o within 50 cycles");
      return;
    end
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_unexpected: request addr %h with empty expected queue", bus.mem_req_addr_o);
      ea = '1;
    end else begin
      ea = exp_q.pop_front();
    end
    chk("issue_addr", 128'(bus.mem_req_addr_o), 128'(ea));
    chk("issue_data", bus.mem_req_data_o, wd(ea));
    chk("issue_rw",   128'(bus.mem_req_rw_o), 128'(exp_rw));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("wait_valid", 128'(bus.mem_req_valid_o), 128'(1'b1));
      chk("wait_addr",  128'(bus.mem_req_addr_o), 128'(ea));
      chk("wait_data",  bus.mem_req_data_o, wd(ea));
      chk("wait_rw",    128'(bus.mem_req_rw_o), 128'(exp_rw));
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = rd;
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;
    chk("done_valid", 128'(bus.mem_req_valid_o), '0);
  endtask

  initial begin
    clear_inputs();

    // Single read on s0 (rows 0-8).
    vq.push_back(mk(1, 1, 0, 32'h0000_1230, 0, 0, 0,      0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h0000_1230, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h0000_1230, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h0000_1230, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h0000_1230, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, D_BEEF,             1, 32'h0000_1230, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 0, D_BEEF, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, D_BEEF, 0));
    // Both ports pulse together after reset: s0, then s1.
    vq.push_back(mk(1, 1, 1, 32'h100, 32'h200, 0, 0,      0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h100, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, DA,                 1, 32'h100, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h200, 0, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, DB,                 1, 32'h200, 0, 0, DA, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, DA, DB));
    // A lone s0 read leaves last_grant=0.
    vq.push_back(mk(0, 1, 0, 32'h300, 0, 0, 0,            0, 0, 0, 0, DA, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, DA, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h300, 0, 0, DA, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, DC,                 1, 32'h300, 0, 0, DA, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 0, DC, DB));
    // Both pending again: s1 first, then s0.
    vq.push_back(mk(0, 1, 1, 32'h400, 32'h500, 0, 0,      0, 0, 0, 0, DC, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, DC, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h500, 0, 0, DC, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, DD,                 1, 32'h500, 0, 0, DC, DB));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, DC, DD));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 32'h400, 0, 0, DC, DD));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, DE,                 1, 32'h400, 0, 0, DC, DD));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 0, DE, DD));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, DE, DD));

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      bus.s0_req_valid_i = vq[i].s0v; bus.s0_req_rw_i = 1'b0;
      bus.s0_req_addr_i = vq[i].a0;   bus.s0_req_data_i = wd(vq[i].a0);
      bus.s1_req_valid_i = vq[i].s1v; bus.s1_req_rw_i = 1'b0;
      bus.s1_req_addr_i = vq[i].a1;   bus.s1_req_data_i = wd(vq[i].a1);
      bus.mem_ready_i = vq[i].mrdy;   bus.mem_data_i = vq[i].mdata;
      chk($sformatf("vec%0d_mv", i),    128'(bus.mem_req_valid_o), 128'(vq[i].ev));
      chk($sformatf("vec%0d_maddr", i), 128'(bus.mem_req_addr_o), vq[i].ev ? 128'(vq[i].eaddr) : '0);
      chk($sformatf("vec%0d_mdata", i), bus.mem_req_data_o, vq[i].ev ? wd(vq[i].eaddr) : '0);
      chk($sformatf("vec%0d_mrw", i),   128'(bus.mem_req_rw_o), '0);
      chk($sformatf("vec%0d_r0", i),    128'(bus.s0_mem_ready_o), 128'(vq[i].er0));
      chk($sformatf("vec%0d_r1", i),    128'(bus.s1_mem_ready_o), 128'(vq[i].er1));
      chk($sformatf("vec%0d_d0", i),    bus.s0_mem_data_o, vq[i].ed0);
      chk($sformatf("vec%0d_d1", i),    bus.s1_mem_data_o, vq[i].ed1);
      chk($sformatf("vec%0d_err", i),   128'(bus.err_o), '0);
      tick();
    end
    clear_inputs();

    // s1 write-back, then allocate, with an s0 read pending in between.
    do_reset();
    exp_q.push_back(32'h0004_0010);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h0008_0010);
    pulse(1, 1'b1, 32'h0004_0010);
    pulse(0, 1'b0, 32'h0000_2000);
    serve(DA, 1'b1, 3);
    chk("wb_r1", 128'(bus.s1_mem_ready_o), 128'(1'b1));
    chk("wb_r0", 128'(bus.s0_mem_ready_o), '0);
    chk("wb_d1", bus.s1_mem_data_o, DA);
    pulse(1, 1'b0, 32'h0008_0010);
    chk("wb_r1_one_cycle", 128'(bus.s1_mem_ready_o), '0);
    serve(DB, 1'b0, 2);
    chk("rd0_r0", 128'(bus.s0_mem_ready_o), 128'(1'b1));
    chk("rd0_r1", 128'(bus.s1_mem_ready_o), '0);
    chk("rd0_d0", bus.s0_mem_data_o, DB);
    serve(DC, 1'b0, 2);
    chk("alloc_r1", 128'(bus.s1_mem_ready_o), 128'(1'b1));
    chk("alloc_r0", 128'(bus.s0_mem_ready_o), '0);
    chk("alloc_d1", bus.s1_mem_data_o, DC);
    chk("alloc_d0_held", bus.s0_mem_data_o, DB);
    chk("alloc_err", 128'(bus.err_o), '0);

    // Overrun: a second s0 pulse while s0 is still pending is dropped.
    do_reset();
    exp_q.push_back(32'h0000_3000);
    pulse(0, 1'b0, 32'h0000_3000);
    pulse(0, 1'b1, 32'h0000_3100);
    chk("ovr_err", 128'(bus.err_o), 128'(2'b01));
    serve(DD, 1'b0, 2);
    chk("ovr_r0", 128'(bus.s0_mem_ready_o), 128'(1'b1));
    chk("ovr_d0", bus.s0_mem_data_o, DD);
    repeat (5) tick();
    chk("ovr_no_retry", 128'(bus.mem_req_valid_o), '0);
    chk("ovr_err_sticky", 128'(bus.err_o), 128'(2'b01));

    // A memory ready while idle reaches neither port.
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = DE;
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_data_i  = '0;
    chk("stray_r0", 128'(bus.s0_mem_ready_o), '0);
    chk("stray_r1", 128'(bus.s1_mem_ready_o), '0);
    chk("stray_d0", bus.s0_mem_data_o, DD);
    chk("stray_state", 128'(bus.dbg_state_o), '0);

    // Reset during WAIT aborts the transaction and clears everything.
    exp_q.push_back(32'h0000_5000);
    pulse(1, 1'b0, 32'h0000_5000);
    begin
      int n;
      n = 0;
      while (bus.mem_req_valid_o !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      chk("rstw_valid_seen", 128'(bus.mem_req_valid_o), 128'(1'b1));
      chk("rstw_addr", 128'(bus.mem_req_addr_o), 128'(exp_q.pop_front()));
    end
    tick();
    chk("rstw_in_wait", 128'(bus.dbg_state_o), 128'(2'b10));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstw");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rstw_pending_cleared", 128'(bus.mem_req_valid_o), '0);

    chk("sb_drained", 128'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
